// File: rtl/gsc_pkg.sv
// gsc_pkg -- shared definitions for the gate sweep checker.
//   op_e      : encoding of the logic op under test (0..5 legal, 6..7 illegal)
//   state_e   : sweep FSM states
//   SETTLE_W  : width of the settle counter (SETTLE is limited to 0..15)
//   op_is_legal(): true for the six defined op codes
package gsc_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned SETTLE_W = 4;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

endpackage

// File: rtl/gsc_golden.sv
// gsc_golden -- combinational reference model of the gate under test.
// Ports:
//   op_i       [2:0]      op code (gsc_pkg::op_e encoding)
//   vec_i      [N_IN-1:0] input vector applied to the gate
//   expected_o            reference output; 0 for illegal op codes
// AND/OR/XOR reduce over all N_IN bits; NAND/NOR/XNOR are their inversions.
module gsc_golden
  import gsc_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op_i,
  input  logic [N_IN-1:0] vec_i,
  output logic            expected_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    expected_o = 1'b0;
    case (op_i)
      OP_AND:  expected_o = &vec_i;
      OP_OR:   expected_o = |vec_i;
      OP_XOR:  expected_o = ^vec_i;
      OP_NAND: expected_o = ~&vec_i;
      OP_NOR:  expected_o = ~|vec_i;
      OP_XNOR: expected_o = ~^vec_i;
      default: expected_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker -- self-running exhaustive checker for an N_IN-input,
// 1-output combinational gate. Drives every vector 0..2^N_IN-1 on stim, waits
// SETTLE idle cycles, then compares dut_out with the golden model.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a sweep (sampled only in IDLE)
//   op [2:0]          op to check, latched on accepted start
//   stim [N_IN-1:0]   drive vector to the gate under test
//   dut_out           gate under test output
//   busy              high from the cycle after start until DONE is left
//   done              one-cycle pulse at end of sweep
//   pass              sweep result, valid from done until the next start
//   err_cnt [ERR_W-1:0]          saturating mismatch count
//   first_fail_vec [N_IN-1:0]    stim value of the first mismatch
//   first_fail_valid             a mismatch was recorded in this sweep
// Build option: define GSC_STOP_ON_FAIL_EN to end the sweep at the first
// mismatch instead of running all vectors.
module gate_sweep_checker
  import gsc_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [SETTLE_W-1:0] SETTLE_CNT = SETTLE_W'(SETTLE);
  localparam logic [ERR_W-1:0]    ERR_MAX    = '1;
  // With no settle time each new vector is checked in the very next cycle.
  localparam state_e AFTER_DRIVE = (SETTLE > 0) ? ST_WAIT : ST_CHECK;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [N_IN-1:0]       stim_q, stim_d;
  logic [SETTLE_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic [N_IN-1:0]       ffv_q, ffv_d;
  logic                  ffval_q, ffval_d;
  logic                  pass_q, pass_d;

  logic                  expected;
  logic                  mismatch;
  logic                  last_vec;
  logic                  stop_early;
  logic [ERR_W-1:0]      err_inc;

  gsc_golden #(.N_IN(N_IN)) u_golden (
    .op_i       (op_q),
    .vec_i      (stim_q),
    .expected_o (expected)
  );

  assign mismatch = (dut_out != expected);
  assign last_vec = &stim_q;
  assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;

`ifdef GSC_STOP_ON_FAIL_EN
  assign stop_early = mismatch;
`else
  assign stop_early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          stim_d  = '0;
          err_d   = '0;
          ffval_d = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = SETTLE_CNT;
          // An illegal op skips the sweep and reports a failed, empty result.
          state_d = op_is_legal(op) ? AFTER_DRIVE : ST_DONE;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= SETTLE_W'(1)) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_inc;
          if (!ffval_q) begin
            ffv_d   = stim_q;
            ffval_d = 1'b1;
          end
        end
        if (last_vec || stop_early) begin
          state_d = ST_DONE;
          // Result includes this cycle's comparison.
          pass_d  = (err_q == '0) && !mismatch && op_is_legal(op_q);
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = SETTLE_CNT;
          state_d = AFTER_DRIVE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      pass_q  <= pass_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign err_cnt          = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker. Three instances cover the
// configurations of interest:
//   u_a : N_IN=2, SETTLE=1  (AND / OR-faulty gate, illegal op, reset abort)
//   u_b : N_IN=4, SETTLE=0  (correct XNOR gate)
//   u_c : N_IN=8, SETTLE=0, ERR_W=4  (NOR op against an output stuck at 1)
// Expectations follow GSC_STOP_ON_FAIL_EN when it is defined.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // instance A
  logic       a_start, a_mode, a_dut_out;
  logic [2:0] a_op;
  logic [1:0] a_stim, a_ffv;
  logic       a_busy, a_done, a_pass, a_ffval;
  logic [7:0] a_err;
  // a_mode=0 : correct AND gate; a_mode=1 : gate wrongly built as OR
  assign a_dut_out = a_mode ? (|a_stim) : (&a_stim);

  // instance B
  logic       b_start, b_dut_out;
  logic [2:0] b_op;
  logic [3:0] b_stim, b_ffv;
  logic       b_busy, b_done, b_pass, b_ffval;
  logic [7:0] b_err;
  assign b_dut_out = ~^b_stim;

  // instance C
  logic       c_start, c_dut_out;
  logic [2:0] c_op;
  logic [7:0] c_stim, c_ffv;
  logic       c_busy, c_done, c_pass, c_ffval;
  logic [3:0] c_err;
  assign c_dut_out = 1'b1;

  gate_sweep_checker #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .op(a_op), .stim(a_stim),
    .dut_out(a_dut_out), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_cnt(a_err), .first_fail_vec(a_ffv), .first_fail_valid(a_ffval)
  );

  gate_sweep_checker #(.N_IN(4), .SETTLE(0), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .op(b_op), .stim(b_stim),
    .dut_out(b_dut_out), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_cnt(b_err), .first_fail_vec(b_ffv), .first_fail_valid(b_ffval)
  );

  gate_sweep_checker #(.N_IN(8), .SETTLE(0), .ERR_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .op(c_op), .stim(c_stim),
    .dut_out(c_dut_out), .busy(c_busy), .done(c_done), .pass(c_pass),
    .err_cnt(c_err), .first_fail_vec(c_ffv), .first_fail_valid(c_ffval)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a sweep on A and wait for done, sampling on falling edges.
  // lat = cycles from the start cycle to the done cycle, -1 on timeout.
  // With chk_stim set, stim must follow 0,0,1,1,2,2,... (SETTLE=1 pacing).
  // With inject set, a second start with another op is pulsed while busy.
  task automatic a_run(input logic [2:0] op, input logic chk_stim, input logic inject,
                       output int lat, output logic stim_ok, output logic busy_ok);
    @(negedge clk);
    a_op    = op;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    lat     = 1;
    stim_ok = 1'b1;
    busy_ok = 1'b1;
    while (!a_done && lat < 40) begin
      if (!a_busy) busy_ok = 1'b0;
      if (chk_stim && (a_stim !== 2'((lat - 1) / 2))) stim_ok = 1'b0;
      if (inject && lat == 3) begin a_start = 1'b1; a_op = 3'd1; end
      if (inject && lat == 4) a_start = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!a_done) lat = -1;
    else if (!a_busy) busy_ok = 1'b0;
  endtask

  int   lat;
  logic stim_ok, busy_ok, seen_done;
  int   exp_lat;

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0; a_op = 3'd0; a_mode = 1'b0;
    b_start = 1'b0; b_op = 3'd0;
    c_start = 1'b0; c_op = 3'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_a_stim",  a_stim,  0);
    check("rst_a_busy",  a_busy,  0);
    check("rst_a_done",  a_done,  0);
    check("rst_a_pass",  a_pass,  0);
    check("rst_a_err",   a_err,   0);
    check("rst_a_ffv",   a_ffv,   0);
    check("rst_a_ffval", a_ffval, 0);
    check("rst_c_err",   c_err,   0);
    rst_n = 1'b1;

    // 1: correct AND gate, start while busy ignored
    a_mode = 1'b0;
    a_run(3'd0, 1'b1, 1'b1, lat, stim_ok, busy_ok);
    check("and_latency", lat, 9);
    check("and_stim_seq", stim_ok, 1);
    check("and_busy", busy_ok, 1);
    check("and_pass", a_pass, 1);
    check("and_err", a_err, 0);
    check("and_ffval", a_ffval, 0);
    check("and_stim_hold", a_stim, 3);

    // 2: gate built as OR, started in the IDLE cycle right after done
    a_mode = 1'b1;
    a_run(3'd0, 1'b1, 1'b0, lat, stim_ok, busy_ok);
`ifdef GSC_STOP_ON_FAIL_EN
    exp_lat = 5;
    check("or_err", a_err, 1);
`else
    exp_lat = 9;
    check("or_err", a_err, 2);
`endif
    check("or_latency", lat, exp_lat);
    check("or_stim_seq", stim_ok, 1);
    check("or_pass", a_pass, 0);
    check("or_ffv", a_ffv, 1);
    check("or_ffval", a_ffval, 1);

    // 3: correct XNOR gate, N_IN=4, no settle time
    @(negedge clk);
    b_op = 3'd5; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    lat = 1;
    while (!b_done && lat < 40) begin @(negedge clk); lat++; end
    if (!b_done) lat = -1;
    check("xnor_latency", lat, 17);
    check("xnor_pass", b_pass, 1);
    check("xnor_err", b_err, 0);
    check("xnor_stim_hold", b_stim, 15);
    @(negedge clk);
    check("xnor_done_pulse", b_done, 0);
    check("xnor_idle_busy", b_busy, 0);
    check("xnor_pass_held", b_pass, 1);

    // 4: illegal op clears previous results and finishes at once
    a_mode = 1'b0;
    a_run(3'd6, 1'b0, 1'b0, lat, stim_ok, busy_ok);
    check("ill_latency_ok", (lat >= 1 && lat <= 2), 1);
    check("ill_pass", a_pass, 0);
    check("ill_err", a_err, 0);
    check("ill_ffval", a_ffval, 0);

    // 5: NOR op against an output stuck at 1, N_IN=8, 4-bit counter
    @(negedge clk);
    c_op = 3'd4; c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    lat = 1;
    while (!c_done && lat < 400) begin @(negedge clk); lat++; end
    if (!c_done) lat = -1;
`ifdef GSC_STOP_ON_FAIL_EN
    check("nor_latency", lat, 3);
    check("nor_err", c_err, 1);
    check("nor_stim_hold", c_stim, 1);
`else
    check("nor_latency", lat, 257);
    check("nor_err_sat", c_err, 15);
    check("nor_stim_hold", c_stim, 255);
`endif
    check("nor_ffv", c_ffv, 1);
    check("nor_ffval", c_ffval, 1);
    check("nor_pass", c_pass, 0);

    // 6: asynchronous reset mid-sweep, then a fresh sweep
    @(negedge clk);
    a_mode = 1'b0; a_op = 3'd0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    lat = 0;
    while (a_stim !== 2'd2 && lat < 20) begin @(negedge clk); lat++; end
    check("abort_reached_stim2", a_stim, 2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_stim", a_stim, 0);
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_ffv", a_ffv, 0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    rst_n = 1'b1;
    a_run(3'd0, 1'b1, 1'b0, lat, stim_ok, busy_ok);
    check("post_abort_latency", lat, 9);
    check("post_abort_pass", a_pass, 1);
    check("post_abort_err", a_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
